// File: rtl/framebuffer_ctrl_pkg.sv
// Shared types and default geometry for the double-buffered framebuffer controller.
package framebuffer_ctrl_pkg;

  localparam int FB_FRAME_WIDTH        = 512;
  localparam int FB_FRAME_HEIGHT       = 384;
  localparam int FB_COLOR_WIDTH        = 12;
  localparam int FB_PADDED_COLOR_WIDTH = 16;
  localparam int FB_COORD_BITS         = 16;
  localparam int FB_SCALE_SHIFT        = 1;
  localparam int FB_ADDR_BITS          = 19;

  typedef enum logic [1:0] {
    FB_ACTIVE    = 2'd0,
    FB_CLEAR     = 2'd1,
    FB_SWAP_WAIT = 2'd2
  } FbState;

  typedef logic [FB_ADDR_BITS-1:0] FbAddr;

endpackage

// File: rtl/framebuffer_ctrl_clear_engine.sv
// Sweeps every pixel of one buffer, issuing one write request per cycle.
module fb_clear_engine
  import framebuffer_ctrl_pkg::*;
#(
  parameter int NUM_PIX   = FB_FRAME_WIDTH * FB_FRAME_HEIGHT,
  parameter int PIX_BITS  = $clog2(NUM_PIX),
  parameter int ADDR_BITS = FB_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 base_i,
  output logic                 we_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 done_o
);

  localparam logic [PIX_BITS-1:0] LAST_PIX = PIX_BITS'(NUM_PIX - 1);

  logic                running_q;
  logic [PIX_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
    end else if (running_q) begin
      if (cnt_q == LAST_PIX) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign we_o   = running_q;
  assign addr_o = (ADDR_BITS'(base_i) << PIX_BITS) | ADDR_BITS'(cnt_q);
  assign done_o = running_q && (cnt_q == LAST_PIX);

endmodule

// File: rtl/framebuffer_ctrl.sv
// Double-buffered framebuffer controller: renderer writes and hardware clear on BRAM port A,
// upscaled display reads on port B, buffer swap aligned to vsync.
module framebuffer_ctrl
  import framebuffer_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH        = FB_FRAME_WIDTH,
  parameter int FRAME_HEIGHT       = FB_FRAME_HEIGHT,
  parameter int COLOR_WIDTH        = FB_COLOR_WIDTH,
  parameter int PADDED_COLOR_WIDTH = FB_PADDED_COLOR_WIDTH,
  parameter int COORD_BITS         = FB_COORD_BITS,
  parameter int SCALE_SHIFT        = FB_SCALE_SHIFT,
  parameter int ADDR_BITS          = FB_ADDR_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [COORD_BITS-1:0]         wr_x,
  input  logic [COORD_BITS-1:0]         wr_y,
  input  logic [PADDED_COLOR_WIDTH-1:0] wr_pixel,
  input  logic                          frame_done,
  input  logic                          clear_req,
  input  logic [COLOR_WIDTH-1:0]        clear_color,
  input  logic [COORD_BITS-1:0]         disp_hcount,
  input  logic [COORD_BITS-1:0]         disp_vcount,
  input  logic                          disp_blank,
  input  logic                          disp_vsync,
  output logic [COLOR_WIDTH-1:0]        disp_pixel,
  output logic                          bram_a_we,
  output logic [ADDR_BITS-1:0]          bram_a_addr,
  output logic [PADDED_COLOR_WIDTH-1:0] bram_a_din,
  output logic [ADDR_BITS-1:0]          bram_b_addr,
  input  logic [PADDED_COLOR_WIDTH-1:0] bram_b_dout,
  output logic                          front_buf,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int NUM_PIX  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int WSHIFT   = $clog2(FRAME_WIDTH);
  localparam int PIX_BITS = $clog2(NUM_PIX);
  localparam logic [COORD_BITS-1:0] W_C = COORD_BITS'(FRAME_WIDTH);
  localparam logic [COORD_BITS-1:0] H_C = COORD_BITS'(FRAME_HEIGHT);

  // Buffer select sits just above the pixel index; the row offset is a shift.
  function automatic logic [ADDR_BITS-1:0] pix_addr(input logic sel,
                                                    input logic [COORD_BITS-1:0] x,
                                                    input logic [COORD_BITS-1:0] y);
    return (ADDR_BITS'(sel) << PIX_BITS) | ((ADDR_BITS'(y) << WSHIFT) + ADDR_BITS'(x));
  endfunction

  FbState                        state_q, state_d;
  logic                          front_buf_q, front_buf_d;
  logic                          swap_pend_q, swap_pend_d;
  logic                          wr_ready_q;
  logic                          vsync_q;
  logic [COLOR_WIDTH-1:0]        clr_color_q;
  logic                          a_we_q, a_we_d;
  logic [ADDR_BITS-1:0]          a_addr_q, a_addr_d;
  logic [PADDED_COLOR_WIDTH-1:0] a_din_q, a_din_d;
  logic [15:0]                   drop_q, drop_d;
  logic [ADDR_BITS-1:0]          b_addr_q;
  logic                          blank_q1, blank_q2, oob_q1, oob_q2;

  logic                          clr_start, clr_we, clr_done;
  logic [ADDR_BITS-1:0]          clr_addr;
  logic                          handshake, in_range, vsync_rise;
  logic [COORD_BITS-1:0]         sx, sy;
  logic [PADDED_COLOR_WIDTH-COLOR_WIDTH-1:0] dout_unused;

  assign handshake  = wr_valid && wr_ready_q;
  assign in_range   = (wr_x < W_C) && (wr_y < H_C);
  assign vsync_rise = disp_vsync && !vsync_q;

  fb_clear_engine #(
    .NUM_PIX   (NUM_PIX),
    .PIX_BITS  (PIX_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (clr_start),
    .base_i  (~front_buf_q),
    .we_o    (clr_we),
    .addr_o  (clr_addr),
    .done_o  (clr_done)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    front_buf_d = front_buf_q;
    swap_pend_d = swap_pend_q;
    clr_start   = 1'b0;
    case (state_q)
      FB_ACTIVE: begin
        if (clear_req) begin
          state_d     = FB_CLEAR;
          clr_start   = 1'b1;
          swap_pend_d = frame_done;
        end else if (frame_done) begin
          state_d     = FB_SWAP_WAIT;
          swap_pend_d = 1'b1;
        end
      end
      FB_CLEAR: begin
        if (frame_done) swap_pend_d = 1'b1;
        if (clr_done) state_d = (swap_pend_q || frame_done) ? FB_SWAP_WAIT : FB_ACTIVE;
      end
      FB_SWAP_WAIT: begin
        if (vsync_rise && !frame_done) begin
          front_buf_d = ~front_buf_q;
          swap_pend_d = 1'b0;
          state_d     = FB_ACTIVE;
        end
      end
      default: state_d = FB_ACTIVE;
    endcase
  end

  // Renderer and clear never collide: clear requests start the cycle after wr_ready drops.
  always_comb begin
    a_we_d   = 1'b0;
    a_addr_d = a_addr_q;
    a_din_d  = a_din_q;
    drop_d   = drop_q;
    if (handshake && in_range) begin
      a_we_d   = 1'b1;
      a_addr_d = pix_addr(~front_buf_q, wr_x, wr_y);
      a_din_d  = wr_pixel;
    end else if (clr_we) begin
      a_we_d   = 1'b1;
      a_addr_d = clr_addr;
      a_din_d  = PADDED_COLOR_WIDTH'(clr_color_q);
    end
    if (handshake && !in_range && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  assign sx = disp_hcount >> SCALE_SHIFT;
  assign sy = disp_vcount >> SCALE_SHIFT;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only control state is reset; the BRAM contents deliberately survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FB_ACTIVE;
      front_buf_q <= 1'b0;
      swap_pend_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      vsync_q     <= 1'b0;
      clr_color_q <= '0;
      a_we_q      <= 1'b0;
      a_addr_q    <= '0;
      a_din_q     <= '0;
      drop_q      <= '0;
      b_addr_q    <= '0;
      blank_q1    <= 1'b1;
      blank_q2    <= 1'b1;
      oob_q1      <= 1'b0;
      oob_q2      <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_buf_q <= front_buf_d;
      swap_pend_q <= swap_pend_d;
      wr_ready_q  <= (state_d == FB_ACTIVE);
      vsync_q     <= disp_vsync;
      if (clr_start) clr_color_q <= clear_color;
      a_we_q      <= a_we_d;
      a_addr_q    <= a_addr_d;
      a_din_q     <= a_din_d;
      drop_q      <= drop_d;
      b_addr_q    <= pix_addr(front_buf_q, sx, sy);
      blank_q1    <= disp_blank;
      blank_q2    <= blank_q1;
      oob_q1      <= (sx >= W_C) || (sy >= H_C);
      oob_q2      <= oob_q1;
    end
  end

  assign dout_unused = bram_b_dout[PADDED_COLOR_WIDTH-1:COLOR_WIDTH];
  assign disp_pixel  = (blank_q2 || oob_q2) ? '0 : bram_b_dout[COLOR_WIDTH-1:0];

  assign wr_ready    = wr_ready_q;
  assign busy        = (state_q == FB_CLEAR) || (state_q == FB_SWAP_WAIT);
  assign front_buf   = front_buf_q;
  assign drop_count  = drop_q;
  assign bram_a_we   = a_we_q;
  assign bram_a_addr = a_addr_q;
  assign bram_a_din  = a_din_q;
  assign bram_b_addr = b_addr_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench for framebuffer_ctrl with a behavioural dual-port BRAM.
// Frame geometry is 64x48 so a full clear is 3072 cycles; buffer bit sits at address bit 12.
module tb_framebuffer_ctrl;

  localparam int W   = 64;
  localparam int H   = 48;
  localparam int NP  = W * H;
  localparam int AB  = 13;
  localparam int CB  = 16;
  localparam int CW  = 12;
  localparam int PCW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_valid, wr_ready;
  logic [CB-1:0]  wr_x, wr_y;
  logic [PCW-1:0] wr_pixel;
  logic           frame_done, clear_req;
  logic [CW-1:0]  clear_color;
  logic [CB-1:0]  disp_hcount, disp_vcount;
  logic           disp_blank, disp_vsync;
  logic [CW-1:0]  disp_pixel;
  logic           bram_a_we;
  logic [AB-1:0]  bram_a_addr, bram_b_addr;
  logic [PCW-1:0] bram_a_din, bram_b_dout;
  logic           front_buf, busy;
  logic [15:0]    drop_count;

  logic [PCW-1:0] mem [0:(1<<AB)-1];
  logic           preload;
  int             n_checks = 0;
  int             n_errors = 0;

  always #5 clk = ~clk;

  framebuffer_ctrl #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .COLOR_WIDTH(CW), .PADDED_COLOR_WIDTH(PCW),
    .COORD_BITS(CB), .SCALE_SHIFT(1), .ADDR_BITS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .frame_done(frame_done), .clear_req(clear_req), .clear_color(clear_color),
    .disp_hcount(disp_hcount), .disp_vcount(disp_vcount), .disp_blank(disp_blank),
    .disp_vsync(disp_vsync), .disp_pixel(disp_pixel),
    .bram_a_we(bram_a_we), .bram_a_addr(bram_a_addr), .bram_a_din(bram_a_din),
    .bram_b_addr(bram_b_addr), .bram_b_dout(bram_b_dout),
    .front_buf(front_buf), .busy(busy), .drop_count(drop_count)
  );

  function automatic logic [PCW-1:0] pat(input int i);
    return PCW'(i) ^ 16'h5A5A;
  endfunction

  // Buffer 0 (and the slack above it) starts with a known pattern.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << (AB-1)); i++) mem[i] <= pat(i);
    end else begin
      if (bram_a_we) mem[bram_a_addr] <= bram_a_din;
    end
    bram_b_dout <= mem[bram_b_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input logic [PCW-1:0] pix);
    wr_valid = 1'b1;
    wr_x     = CB'(x);
    wr_y     = CB'(y);
    wr_pixel = pix;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic show(input int h, input int v, input logic blank);
    disp_hcount = CB'(h);
    disp_vcount = CB'(v);
    disp_blank  = blank;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int bad;
    logic fb_before;

    rst_n = 1'b0; preload = 1'b1;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
    frame_done = 1'b0; clear_req = 1'b0; clear_color = '0;
    disp_hcount = '0; disp_vcount = '0; disp_blank = 1'b1; disp_vsync = 1'b0;
    tick();
    preload = 1'b0;
    tick();

    check("rst_wr_ready",   32'(wr_ready),   32'd1);
    check("rst_a_we",       32'(bram_a_we),  32'd0);
    check("rst_front_buf",  32'(front_buf),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_disp_pixel", 32'(disp_pixel), 32'd0);
    rst_n = 1'b1;
    tick();

    // In-range write lands in back buffer 1 one cycle after the handshake.
    write_px(10, 3, 16'h0ABC);
    check("wr_a_we",   32'(bram_a_we),   32'd1);
    check("wr_a_addr", 32'(bram_a_addr), 32'h10CA);
    check("wr_a_din",  32'(bram_a_din),  32'h0ABC);
    tick();
    check("wr_a_we_off", 32'(bram_a_we), 32'd0);

    write_px(64, 0, 16'h0111);
    check("drop_x_a_we", 32'(bram_a_we), 32'd0);
    write_px(0, 48, 16'h0222);
    check("drop_y_a_we", 32'(bram_a_we), 32'd0);
    check("drop_count",  32'(drop_count), 32'd2);
    check("drop_ready",  32'(wr_ready),   32'd1);

    clear_color = 12'hF00; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (!wr_ready && cnt < 5000) begin
      cnt++;
      tick();
    end
    check("clear_ready_low_cycles", 32'(cnt), 32'(NP));
    tick(); tick();
    bad = 0;
    for (int i = 0; i < NP; i++) if (mem[(1 << (AB-1)) + i] !== 16'h0F00) bad++;
    check("clear_back_bad_words", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < NP; i++) if (mem[i] !== pat(i)) bad++;
    check("clear_front_changed_words", 32'(bad), 32'd0);

    // Swap request, vsync edge 100 cycles after frame_done.
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    cnt = 0;
    fb_before = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (busy) cnt++;
      if (i == 99) begin
        fb_before  = front_buf;
        disp_vsync = 1'b1;
      end
      tick();
    end
    check("swap_busy_cycles",  32'(cnt),       32'd100);
    check("swap_front_before", 32'(fb_before), 32'd0);
    check("swap_front_after",  32'(front_buf), 32'd1);
    check("swap_busy_after",   32'(busy),      32'd0);
    disp_vsync = 1'b0;
    write_px(10, 3, 16'h0123);
    check("swap_wr_a_addr", 32'(bram_a_addr), 32'h00CA);
    check("swap_wr_a_din",  32'(bram_a_din),  32'h0123);

    // Vsync edge coinciding with frame_done is not used; the next edge is.
    frame_done = 1'b1; disp_vsync = 1'b1;
    tick();
    frame_done = 1'b0;
    check("coinc_busy",  32'(busy),      32'd1);
    check("coinc_front", 32'(front_buf), 32'd1);
    tick(); tick(); tick();
    disp_vsync = 1'b0;
    tick(); tick();
    check("coinc_still_waiting", 32'(front_buf), 32'd1);
    disp_vsync = 1'b1;
    tick();
    check("coinc_front_next_edge", 32'(front_buf), 32'd0);
    check("coinc_busy_next_edge",  32'(busy),      32'd0);
    disp_vsync = 1'b0;
    tick();

    // Display reads front buffer 0 with 2x upscale.
    show(20, 6, 1'b0);
    check("disp_pixel_20_6", 32'(disp_pixel), 32'h123);
    show(20, 6, 1'b1);
    check("disp_blank",      32'(disp_pixel), 32'h000);
    show(3, 1, 1'b0);
    check("disp_pixel_3_1",  32'(disp_pixel), 32'hA5B);
    show(200, 0, 1'b0);
    check("disp_oob_x",      32'(disp_pixel), 32'h000);
    show(0, 96, 1'b0);
    check("disp_oob_y",      32'(disp_pixel), 32'h000);
    disp_blank = 1'b1;

    // clear_req and frame_done together: clear first, vsync during clear ignored.
    clear_color = 12'h0AB; clear_req = 1'b1; frame_done = 1'b1;
    tick();
    clear_req = 1'b0; frame_done = 1'b0;
    for (int i = 0; i < NP + 4; i++) begin
      if (i == 1000) disp_vsync = 1'b1;
      if (i == 1001) disp_vsync = 1'b0;
      tick();
    end
    check("both_busy_after_clear",  32'(busy),      32'd1);
    check("both_ready_after_clear", 32'(wr_ready),  32'd0);
    check("both_front_held",        32'(front_buf), 32'd0);
    disp_vsync = 1'b1;
    tick();
    check("both_front_swapped", 32'(front_buf), 32'd1);
    check("both_ready_back",    32'(wr_ready),  32'd1);
    disp_vsync = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < NP; i++) if (mem[(1 << (AB-1)) + i] !== 16'h00AB) bad++;
    check("both_clear_bad_words", 32'(bad), 32'd0);

    // Reset in the middle of a clear.
    clear_color = 12'h0FF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midrst_busy_before", 32'(busy),       32'd1);
    check("midrst_drop_before", 32'(drop_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(wr_ready),   32'd1);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_front", 32'(front_buf),  32'd0);
    check("midrst_drop",  32'(drop_count), 32'd0);
    check("midrst_a_we",  32'(bram_a_we),  32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("midrst_ready_after", 32'(wr_ready),  32'd1);
    check("midrst_busy_after",  32'(busy),      32'd0);
    check("midrst_a_we_after",  32'(bram_a_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
